// File: rtl/seq_multiplier_nxm.sv
// Sequential shift-add multiplier: one bit of b per clock, LSB first.
// Result appears B_W cycles after start with a one-cycle done pulse.
module seq_multiplier_nxm #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W = A_W + B_W;
  localparam int C_W = (B_W < 2) ? 1 : $clog2(B_W + 1);
  localparam logic [C_W-1:0] LAST = C_W'(B_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [P_W-1:0] a_sh;
  logic [B_W-1:0] b_sh;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] acc_next;
  logic [C_W-1:0] cnt;

  // a is pre-shifted and b shifted down each step, equivalent to (a << cnt) gated by b[cnt]
  always_comb begin
    acc_next = acc;
    if (b_sh[0]) acc_next = acc + a_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= P_W'(a);
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          acc  <= acc_next;
          cnt  <= cnt + C_W'(1);
          if (cnt == LAST) begin
            product <= acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_nxm.sv
// Bench for seq_multiplier_nxm: directed scenarios plus random operands
// against a plain a*b model with fixed B_W-cycle latency.
module tb_seq_multiplier_nxm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [2:0]  b;
  logic        busy;
  logic        done;
  logic [6:0]  product;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int tests = 0;
  int fails = 0;
  logic [63:0] prev_p;
  logic [63:0] prev_p8;

  always #5 clk = ~clk;

  seq_multiplier_nxm dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_multiplier_nxm #(.A_W(8), .B_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one operation on the 4x3 instance: busy for 3 cycles, done in the 3rd after start
  task automatic run4(input logic [3:0] av, input logic [2:0] bv);
    logic [63:0] exp;
    exp = 64'(av) * 64'(bv);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("run4_busy", busy, 1);
      chk("run4_nodone", done, 0);
      chk("run4_hold", product, prev_p);
      tick();
    end
    chk("run4_done", done, 1);
    chk("run4_idle", busy, 0);
    chk("run4_product", product, exp);
    prev_p = exp;
    tick();
    chk("run4_pulse", done, 0);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv);
    logic [63:0] exp;
    exp = 64'(av) * 64'(bv);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("run8_busy", busy8, 1);
      chk("run8_nodone", done8, 0);
      tick();
    end
    chk("run8_done", done8, 1);
    chk("run8_product", product8, exp);
    prev_p8 = exp;
    tick();
    chk("run8_pulse", done8, 0);
  endtask

  initial begin
    int unsigned ndone;
    logic [3:0] ra;
    logic [2:0] rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    prev_p = 0; prev_p8 = 0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_product8", product8, 0);
    tick(); tick();
    rst = 1'b0;

    run4(4'd0, 3'd0);
    run4(4'd1, 3'd3);
    run4(4'd6, 3'd7);
    run4(4'd10, 3'd5);
    run4(4'd15, 3'd3);
    run4(4'd13, 3'd2);
    run4(4'd15, 3'd7);

    // idle holds product
    tick(); tick();
    chk("idle_hold", product, prev_p);
    chk("idle_busy", busy, 0);

    // start held high: done every 4th cycle
    a = 4'd15; b = 3'd7; start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("cont_busy", busy, ((j % 4) < 3) ? 1 : 0);
      chk("cont_done", done, ((j % 4) == 3) ? 1 : 0);
      if ((j % 4) == 3) chk("cont_product", product, 105);
    end
    start = 1'b0;
    tick();
    chk("cont_stop", busy, 0);
    prev_p = 105;

    // start and operand changes during RUN are ignored
    a = 4'd6; b = 3'd7; start = 1'b1;
    tick();
    a = 4'd15; b = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      if (done) begin
        ndone++;
        chk("ignore_product", product, 42);
      end
      tick();
    end
    chk("ignore_one_done", ndone, 1);
    chk("ignore_final", product, 42);
    prev_p = 42;

    // reset mid-RUN aborts with no done pulse
    a = 4'd15; b = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    tick();
    rst = 1'b0;
    prev_p = 0;
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_hold", product, 0);

    // start honoured on the first edge after reset release
    rst = 1'b1;
    tick();
    #2 rst = 1'b0;
    run4(4'd9, 3'd6);

    for (int k = 0; k < 20; k++) begin
      ra = 4'($urandom);
      rb = 3'($urandom);
      run4(ra, rb);
    end

    run8(8'd255, 8'd255);
    run8(8'd0, 8'd200);
    for (int k = 0; k < 4; k++) run8(8'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_multiplier_nxm.md
SEQ_MULTIPLIER_NXM -- requirements
Module: seq_multiplier_nxm

Interface
REQ-001 SHALL provide parameter A_W, default 4: multiplicand width in bits, A_W >= 1.
REQ-002 SHALL provide parameter B_W, default 3: multiplier width in bits, B_W >= 1.
REQ-003 SHALL provide port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL provide port start, input, 1 bit: request to begin a multiplication, sampled on the rising edge of clk.
REQ-006 SHALL provide port a, input, A_W bits: unsigned multiplicand.
REQ-007 SHALL provide port b, input, B_W bits: unsigned multiplier.
REQ-008 SHALL provide port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL provide port done, output, 1 bit: single-cycle pulse marking the cycle a new product becomes valid.
REQ-010 SHALL provide port product, output, A_W+B_W bits: unsigned result a*b.

Function
REQ-011 SHALL implement a shift-add multiplier that processes one bit of b per clock, LSB first.
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 at a rising edge, latch a and b, clear the accumulator, load the bit counter with 0, and enter RUN.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE.
REQ-015 SHALL, in DONE with start=0, return to IDLE on the next edge.
REQ-016 SHALL, at each RUN edge, add (latched a << counter) to the accumulator when latched b[counter]=1, then increment the counter.
REQ-017 SHALL, at the RUN edge that processes bit B_W-1, write the final accumulator value to product and enter DONE.
REQ-018 SHALL give a latency of exactly B_W clock cycles from the edge that samples start to the first cycle in which done=1.
REQ-019 SHALL drive busy=1 in RUN and busy=0 in IDLE and DONE.
REQ-020 SHALL drive done=1 only in DONE, for exactly one cycle per accepted start.
REQ-021 SHALL hold product stable from its DONE update until the next DONE update, including across IDLE and RUN.
REQ-022 SHALL ignore start while busy=1; a and b changes during RUN SHALL NOT affect the result.
REQ-023 SHALL accept start in the DONE cycle, giving back-to-back operations with no idle gap: done, then busy on the next edge.
REQ-024 SHALL size the accumulator to A_W+B_W bits, so no overflow is possible; the product for all-ones operands is (2^A_W-1)*(2^B_W-1).
REQ-025 SHALL size the counter to ceil(log2(B_W+1)) bits minimum, and SHALL NOT wrap before reaching B_W-1.
REQ-026 SHALL treat an operand of zero as a normal operation with the full B_W-cycle latency; no early termination.

Reset
REQ-027 SHALL, while rst=1 regardless of clk, force state=IDLE, busy=0, done=0, product=0, accumulator=0, and counter=0.
REQ-028 SHALL, on rst asserted mid-RUN, abort the operation, produce no done pulse, and leave product at 0.
REQ-029 SHALL honour start at the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover this directed scenario: reset, then a=0, b=0, start for 1 cycle -> done pulses 3 cycles later, product=0.
REQ-031 SHALL cover this directed scenario: vector sequence (1,3), (6,7), (10,5), (15,3), (13,2), (15,7) with defaults -> products 3, 42, 50, 45, 26, 105, each exactly 3 cycles after start.
REQ-032 SHALL cover this directed scenario: start held high continuously with a=15, b=7 -> done every 4th cycle, busy high 3 of every 4 cycles, product=105 each time.
REQ-033 SHALL cover this directed scenario: start (6,7), then change a/b and pulse start during RUN -> product=42, only one done pulse.
REQ-034 SHALL cover this directed scenario: start (15,7), assert rst after 1 RUN cycle -> busy=0, done=0, product=0 immediately, with no later done pulse.
REQ-035 SHALL cover this directed scenario: A_W=8, B_W=8, a=255, b=255 -> product=65025 after 8 cycles.
